keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad: drives one column low at a time, samples the rows, debounces, and emits one decoded key event per press.
- Sits on the input side of the calculator, opposite the multiplexed 7-segment display driver.
- Replaces the switch-based operand and operator entry with keypad digits (0-9) and function keys (A-D, *, #).

---
 rtl/calc_pkg.sv | 18 +
 rtl/keypad_decode.sv | 36 +++
 rtl/keypad_scanner.sv | 166 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad function-key codes and the scanner state encoding.
package calc_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    PRESSED,
    REL_DB
  } scan_state_t;

endpackage

// File: rtl/keypad_decode.sv
// Combinational key map for the 4x4 keypad: (row, column) -> key code and digit flag.
module keypad_decode
  import calc_pkg::*;
(
  input  logic [1:0] row_idx,
  input  logic [1:0] col_idx,
  output logic [3:0] code,
  output logic       digit
);

  // Row 0 is the top row, column 0 the left column.
  always_comb begin
    code = 4'd0;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = KEY_D;
      default:  code = 4'd0;
    endcase
    digit = (code < 4'd10);
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-hot-low column drive, synchronized row sampling,
// press/release debouncing and a single registered key event per press.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_digit,
  output logic       key_held
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB       = 4'(DEBOUNCE);

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div_cnt;
  logic             tick, any_low;
  logic [1:0]       win_row;
  logic [3:0]       dec_code;
  logic             dec_digit;
  logic [3:0]       cnt_inc;

  scan_state_t state, state_next;
  logic [1:0]  col_idx, col_idx_next, row_lat, row_lat_next;
  logic [3:0]  cnt, cnt_next, col_next, code_next;
  logic        valid_next, digit_next, held_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
      div_cnt  <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      div_cnt  <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  assign tick    = (div_cnt == DIV_LAST);
  assign any_low = ~&row_sync;
  assign cnt_inc = (cnt >= DB) ? DB : cnt + 4'd1;

  // Lowest-index low row wins when several rows are pulled down together.
  always_comb begin
    win_row = 2'd3;
    if      (!row_sync[0]) win_row = 2'd0;
    else if (!row_sync[1]) win_row = 2'd1;
    else if (!row_sync[2]) win_row = 2'd2;
  end

  keypad_decode u_decode (
    .row_idx (win_row),
    .col_idx (col_idx),
    .code    (dec_code),
    .digit   (dec_digit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      row_lat   <= 2'd0;
      cnt       <= 4'd0;
      col       <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_digit <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_next;
      col_idx   <= col_idx_next;
      row_lat   <= row_lat_next;
      cnt       <= cnt_next;
      col       <= col_next;
      key_valid <= valid_next;
      key_code  <= code_next;
      key_digit <= digit_next;
      key_held  <= held_next;
    end
  end

  // Every transition happens on a sample tick; the event is decoded from the
  // column currently driven and the winning row, which equals the latched row.
  always_comb begin
    state_next   = state;
    col_idx_next = col_idx;
    row_lat_next = row_lat;
    cnt_next     = cnt;
    valid_next   = 1'b0;
    code_next    = key_code;
    digit_next   = key_digit;
    held_next    = key_held;
    if (tick) begin
      case (state)
        SCAN: begin
          if (!any_low) begin
            col_idx_next = col_idx + 2'd1;
          end else begin
            row_lat_next = win_row;
            cnt_next     = 4'd1;
            if (DB == 4'd1) begin
              state_next = PRESSED;
              valid_next = 1'b1;
              code_next  = dec_code;
              digit_next = dec_digit;
              held_next  = 1'b1;
            end else begin
              state_next = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (any_low && (win_row == row_lat)) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB) begin
              state_next = PRESSED;
              valid_next = 1'b1;
              code_next  = dec_code;
              digit_next = dec_digit;
              held_next  = 1'b1;
            end
          end else begin
            state_next   = SCAN;
            col_idx_next = col_idx + 2'd1;
          end
        end
        PRESSED: begin
          if (!any_low) begin
            cnt_next = 4'd1;
            if (DB == 4'd1) begin
              state_next   = SCAN;
              held_next    = 1'b0;
              col_idx_next = col_idx + 2'd1;
            end else begin
              state_next = REL_DB;
            end
          end
        end
        REL_DB: begin
          if (!any_low) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB) begin
              state_next   = SCAN;
              held_next    = 1'b0;
              col_idx_next = col_idx + 2'd1;
            end
          end else begin
            state_next = PRESSED;
          end
        end
        default: state_next = SCAN;
      endcase
    end
    col_next = ~(4'b0001 << col_idx_next);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives the rows and
// expected key events are queued at stimulus time, then checked on each key_valid.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 8;
  localparam int DEBOUNCE = 3;

  typedef struct packed {
    logic [3:0] code;
    logic       digit;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_digit, key_held;
  logic [15:0] keys = '0;
  logic        prev_valid = 1'b0;
  int          total = 0, bad = 0, ev_count = 0, cyc = 0, n = 0;
  exp_t        sb_q[$];
  logic [3:0]  exp_col [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_digit (key_digit),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column only while that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int r, input int c, input logic down);
    keys[r*4+c] = down;
  endtask

  task automatic push_expect(input logic [3:0] code);
    exp_t e;
    e.code  = code;
    e.digit = (code < 4'd10);
    sb_q.push_back(e);
  endtask

  task automatic wait_event(input string tag);
    int start;
    int k;
    start = ev_count;
    k = 0;
    while (ev_count == start && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_output({tag, "_events"}, 32'(ev_count - start), 32'd1);
  endtask

  task automatic wait_release(input string tag, output int cycles);
    cycles = 0;
    while (key_held && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    check_output({tag, "_released"}, 32'(key_held), 32'd0);
  endtask

  task automatic wait_col(input string tag, input logic [3:0] target);
    int k;
    k = 0;
    while (col !== target && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_output({tag, "_col_reached"}, 32'(col), 32'(target));
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (key_valid) begin
      check_output("valid_pulse_width", 32'(prev_valid), 32'd0);
      if (sb_q.size() == 0) begin
        check_output("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_output("ev_code", 32'(key_code), 32'(e.code));
        check_output("ev_digit", 32'(key_digit), 32'(e.digit));
        check_output("ev_held", 32'(key_held), 32'd1);
      end
      ev_count++;
    end
    prev_valid = key_valid;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_col", 32'(col), 32'hE);
    check_output("rst_valid", 32'(key_valid), 32'd0);
    check_output("rst_code", 32'(key_code), 32'd0);
    check_output("rst_digit", 32'(key_digit), 32'd0);
    check_output("rst_held", 32'(key_held), 32'd0);

    reset = 1'b1;
    for (int s = 0; s < 5; s++) begin
      check_output($sformatf("scan_col_%0d", s), 32'(col), 32'(exp_col[s]));
      repeat (SCAN_DIV) @(negedge clk);
    end

    // Clean press of "5" (row 1, column 1).
    apply_stimulus(1, 1, 1'b1);
    push_expect(4'd5);
    wait_event("press5");
    for (int i = 0; i < 3; i++) begin
      repeat (SCAN_DIV) @(negedge clk);
      check_output("press5_col_hold", 32'(col), 32'hD);
    end
    check_output("press5_held", 32'(key_held), 32'd1);
    apply_stimulus(1, 1, 1'b0);
    wait_release("press5", n);
    check_output("press5_rel_latency", 32'(n >= 19 && n <= 26), 32'd1);

    // Bounce on "A": starting on an odd cycle keeps the 10-cycle toggle period
    // from ever lining up three consecutive on-samples at the 8-cycle tick rate.
    @(negedge clk);
    while (cyc[0] == 1'b0) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(0, 3, (i % 2) == 0);
      repeat (5) @(negedge clk);
    end
    apply_stimulus(0, 3, 1'b1);
    push_expect(4'd10);
    wait_event("bounceA");
    repeat (40) @(negedge clk);
    check_output("bounceA_held", 32'(key_held), 32'd1);
    apply_stimulus(0, 3, 1'b0);
    wait_release("bounceA", n);

    // Release glitch on "#": one high tick must not end the press or re-emit.
    apply_stimulus(3, 2, 1'b1);
    push_expect(4'd15);
    wait_event("hash");
    apply_stimulus(3, 2, 1'b0);
    repeat (SCAN_DIV) @(negedge clk);
    apply_stimulus(3, 2, 1'b1);
    repeat (40) @(negedge clk);
    check_output("hash_held", 32'(key_held), 32'd1);
    check_output("hash_code_hold", 32'(key_code), 32'd15);
    apply_stimulus(3, 2, 1'b0);
    wait_release("hash", n);

    // "*" and "1" together, then "9" while "1" is held.
    apply_stimulus(3, 0, 1'b1);
    apply_stimulus(0, 0, 1'b1);
    push_expect(4'd1);
    wait_event("multi");
    apply_stimulus(2, 2, 1'b1);
    repeat (40) @(negedge clk);
    check_output("multi_held", 32'(key_held), 32'd1);
    check_output("multi_code_hold", 32'(key_code), 32'd1);
    apply_stimulus(2, 2, 1'b0);
    apply_stimulus(3, 0, 1'b0);
    apply_stimulus(0, 0, 1'b0);
    wait_release("multi", n);

    // Reset while "D" is in press debounce, key still down across reset.
    wait_col("rstmid_pre", 4'b1011);
    apply_stimulus(3, 3, 1'b1);
    wait_col("rstmid", 4'b0111);
    repeat (12) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rstmid_col", 32'(col), 32'hE);
    check_output("rstmid_valid", 32'(key_valid), 32'd0);
    check_output("rstmid_code", 32'(key_code), 32'd0);
    check_output("rstmid_digit", 32'(key_digit), 32'd0);
    check_output("rstmid_held", 32'(key_held), 32'd0);
    push_expect(4'd13);
    reset = 1'b1;
    wait_event("rstmid");
    check_output("rstmid_col_hold", 32'(col), 32'h7);
    apply_stimulus(3, 3, 1'b0);
    wait_release("rstmid", n);

    repeat (20) @(negedge clk);
    check_output("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
